// File: rtl/vga_pkg.sv
// vga_pkg: default VGA timing constants, per-axis timing struct and width helper.
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int DEF_CLK_DIV = 2;
  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } vga_axis_t;
  function automatic int axis_total(input vga_axis_t a);
    return int'(a.active) + int'(a.fp) + int'(a.sync) + int'(a.bp);
  endfunction
  function automatic int clog2w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/vga_pix_div.sv
// vga_pix_div: pixel clock divider producing a registered vga_clk and a one-clock pixel tick.
module vga_pix_div import vga_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic vga_clk,
  output logic tick
);
  localparam int DW = clog2w(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  logic [DW-1:0] div_q, div_d;
  logic vga_clk_q;
  always_comb begin
    tick = en && (div_q == DIV_MAX);
    div_d = !en ? div_q : tick ? '0 : div_q + DW'(1);
  end
  // vga_clk is decoded from the next divider value so it tracks div without a cycle of lag
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_q <= '0;
      vga_clk_q <= 1'b0;
    end else begin
      div_q <= div_d;
      vga_clk_q <= (div_d >= DIV_HALF);
    end
  end
  assign vga_clk = vga_clk_q;
endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA sync/blank/colour timing generator; VGA_TEST_PATTERN_EN adds 8-bar test pattern.
module vga_timing_ctrl import vga_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int COLOR_W = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
  input  logic pattern_sel,
  output logic vga_clk,
  output logic hsync,
  output logic vsync,
  output logic blank,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic [clog2w(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] x,
  output logic [clog2w(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] y,
  output logic line_start,
  output logic frame_start
);
  localparam vga_axis_t H_AX = '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
  localparam vga_axis_t V_AX = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};
  localparam int H_TOTAL = axis_total(H_AX);
  localparam int V_TOTAL = axis_total(V_AX);
  localparam int XW = clog2w(H_TOTAL);
  localparam int YW = clog2w(V_TOTAL);
  localparam logic [XW-1:0] H_MAX = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_SS = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_SE = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_MAX = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_SS = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] V_SE = YW'(V_ACTIVE + V_FP + V_SYNC);
  logic tick, x_wrap, y_wrap, act, in_hs, in_vs;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic hs_q, vs_q, bl_q, ls_q, fs_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q, cr, cg, cb;
  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clock(clock),
    .reset(reset),
    .en(en),
    .vga_clk(vga_clk),
    .tick(tick)
  );
  always_comb begin
    x_wrap = (x_q == H_MAX);
    y_wrap = (y_q == V_MAX);
    x_d = !tick ? x_q : x_wrap ? '0 : x_q + XW'(1);
    y_d = !(tick && x_wrap) ? y_q : y_wrap ? '0 : y_q + YW'(1);
    act = (x_q < H_ACT) && (y_q < V_ACT);
    in_hs = (x_q >= H_SS) && (x_q < H_SE);
    in_vs = (y_q >= V_SS) && (y_q < V_SE);
  end
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar;
  always_comb begin
    bar = 3'(({3'b000, x_q} << 3) / (XW+3)'(H_ACTIVE));
    cr = pattern_sel ? {COLOR_W{bar[0]}} : pix_r;
    cg = pattern_sel ? {COLOR_W{bar[1]}} : pix_g;
    cb = pattern_sel ? {COLOR_W{bar[2]}} : pix_b;
  end
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  always_comb begin
    cr = pix_r;
    cg = pix_g;
    cb = pix_b;
  end
`endif
  // outputs are decoded from the pixel that the tick ends, so they trail x,y by one pixel
  always_ff @(posedge clock) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
      hs_q <= ~HSYNC_POL;
      vs_q <= ~VSYNC_POL;
      bl_q <= 1'b0;
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      ls_q <= tick && x_wrap;
      fs_q <= tick && x_wrap && y_wrap;
      if (tick) begin
        hs_q <= in_hs ? HSYNC_POL : ~HSYNC_POL;
        vs_q <= in_vs ? VSYNC_POL : ~VSYNC_POL;
        bl_q <= act;
        r_q <= act ? cr : '0;
        g_q <= act ? cg : '0;
        b_q <= act ? cb : '0;
      end
    end
  end
  assign x = x_q;
  assign y = y_q;
  assign hsync = hs_q;
  assign vsync = vs_q;
  assign blank = bl_q;
  assign r = r_q;
  assign g = g_q;
  assign b = b_q;
  assign line_start = ls_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: table, directed and random checks of vga_timing_ctrl against a pixel-count model.
module tb_vga_timing_ctrl;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int CD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  logic clock = 1'b0, reset = 1'b0, en = 1'b0, pattern_sel = 1'b0;
  logic [7:0] pix_r = '0, pix_g = '0, pix_b = '0;
  logic vga_clk, hsync, vsync, blank, line_start, frame_start;
  logic [7:0] r, g, b;
  logic [3:0] x;
  logic [2:0] y;
  int passed = 0, total = 0;
  always #5 clock = ~clock;
  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(CD), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_W(8)
  ) dut (
    .clock(clock), .reset(reset), .en(en),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pattern_sel(pattern_sel),
    .vga_clk(vga_clk), .hsync(hsync), .vsync(vsync), .blank(blank),
    .r(r), .g(g), .b(b), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start)
  );
  // model: n = enabled clocks since reset; pixel p ends on the clock where n%CD == CD-1
  int n, p, px, py;
  logic m_hs, m_vs, m_bl, m_ls, m_fs;
  logic [7:0] m_r, m_g, m_b;
  always @(posedge clock) begin
    if (!reset) begin
      n = 0; m_hs = 1; m_vs = 1; m_bl = 0; m_r = 0; m_g = 0; m_b = 0; m_ls = 0; m_fs = 0;
    end else if (en) begin
      m_ls = 0; m_fs = 0;
      if (n % CD == CD - 1) begin
        p = n / CD; px = p % HT; py = (p / HT) % VT;
        m_hs = !(px >= HA + HF && px < HA + HF + HS);
        m_vs = !(py >= VA + VF && py < VA + VF + VS);
        m_bl = px < HA && py < VA;
        m_r = pix_r; m_g = pix_g; m_b = pix_b;
`ifdef VGA_TEST_PATTERN_EN
        if (pattern_sel) begin
          m_r = ((px * 8 / HA) & 1) != 0 ? 8'hFF : 8'h00;
          m_g = ((px * 8 / HA) & 2) != 0 ? 8'hFF : 8'h00;
          m_b = ((px * 8 / HA) & 4) != 0 ? 8'hFF : 8'h00;
        end
`endif
        if (!m_bl) begin m_r = 0; m_g = 0; m_b = 0; end
        m_ls = px == HT - 1;
        m_fs = m_ls && py == VT - 1;
      end
      n++;
    end else begin
      m_ls = 0; m_fs = 0;
    end
  end
  function automatic logic [63:0] exp_vec();
    return {27'd0, 4'((n / CD) % HT), 3'((n / CD / HT) % VT), 1'((n % CD) >= CD / 2),
            m_hs, m_vs, m_bl, m_r, m_g, m_b, m_ls, m_fs};
  endfunction
  function automatic logic [63:0] dut_vec();
    return {27'd0, x, y, vga_clk, hsync, vsync, blank, r, g, b, line_start, frame_start};
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
  endtask
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
    chk("model", dut_vec(), exp_vec());
  endtask
  task automatic do_reset();
    reset = 0;
    cyc();
    reset = 1;
  endtask
  typedef struct {
    int n;
    logic [3:0] x;
    logic [2:0] y;
    logic hs, vs, bl;
    logic [7:0] r;
  } vec_t;
  vec_t tbl[14];
  int cnt, c, f1, f2, nls, bad_ls, last_ls, hs_low;
  initial begin
    tbl[0] = '{0, 0, 0, 1, 1, 0, 0};
    tbl[1] = '{2, 1, 0, 1, 1, 1, 0};
    tbl[2] = '{12, 6, 0, 1, 1, 1, 5};
    tbl[3] = '{17, 8, 0, 1, 1, 1, 7};
    tbl[4] = '{18, 9, 0, 1, 1, 0, 0};
    tbl[5] = '{22, 11, 0, 0, 1, 0, 0};
    tbl[6] = '{26, 13, 0, 0, 1, 0, 0};
    tbl[7] = '{28, 14, 0, 1, 1, 0, 0};
    tbl[8] = '{30, 0, 1, 1, 1, 0, 0};
    tbl[9] = '{32, 1, 1, 1, 1, 1, 0};
    tbl[10] = '{152, 1, 5, 1, 0, 0, 0};
    tbl[11] = '{210, 0, 7, 1, 0, 0, 0};
    tbl[12] = '{212, 1, 7, 1, 1, 0, 0};
    tbl[13] = '{240, 0, 0, 1, 1, 0, 0};
    @(negedge clock);
    do_reset();
    chk("reset_vals", dut_vec(), {27'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0, 2'b00});
    en = 1; cnt = 0;
    for (int i = 0; i < 14; i++) begin
      while (cnt < tbl[i].n) begin
        pix_r = {4'b0, x}; pix_g = 8'($urandom); pix_b = 8'($urandom);
        cyc(); cnt++;
      end
      chk("tbl_xy", {x, y}, {tbl[i].x, tbl[i].y});
      chk("tbl_sync_blank", {hsync, vsync, blank}, {tbl[i].hs, tbl[i].vs, tbl[i].bl});
      chk("tbl_r", r, tbl[i].r);
    end
    do_reset();
    f1 = 0; f2 = 0; nls = 0; bad_ls = 0; last_ls = 0; hs_low = 0;
    for (c = 1; c <= 490; c++) begin
      pix_r = 8'($urandom); cyc();
      if (c <= 480 && !hsync) hs_low++;
      if (frame_start) begin if (f1 == 0) f1 = c; else if (f2 == 0) f2 = c; end
      if (line_start) begin
        if (last_ls != 0 && c - last_ls != 30) bad_ls++;
        last_ls = c; nls++;
      end
    end
    chk("first_frame_start", f1, 240);
    chk("frame_period", f2 - f1, 240);
    chk("line_count", nls, 16);
    chk("line_period_bad", bad_ls, 0);
    chk("hsync_low_clocks", hs_low, 96);
    do_reset();
    for (int i = 0; i < 2 * (5 * HT + 11) + 1; i++) cyc();
    chk("pre_reset_xy", {x, y}, {4'd11, 3'd5});
    reset = 0; en = 1;
    cyc();
    chk("mid_reset_vals", dut_vec(), {27'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0, 2'b00});
    reset = 1; c = 0;
    do begin cyc(); c++; if (c == 2) chk("first_tick_x", x, 4'd1); end
    while (!frame_start && c < 300);
    chk("frame_after_reset", c, 240);
    do_reset();
    for (int i = 0; i < 13; i++) cyc();
    en = 0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("hold_x_vga", {x, vga_clk}, {4'd6, 1'b1});
    end
    en = 1;
    cyc();
    chk("resume_x", x, 4'd7);
    for (int i = 0; i < 40; i++) cyc();
    pattern_sel = 1; pix_r = 8'h5A; pix_g = 8'hC3; pix_b = 8'h3C;
    do_reset();
    cyc(); cyc();
`ifdef VGA_TEST_PATTERN_EN
    chk("pattern_bar0", {r, g, b}, 24'h000000);
`else
    chk("passthru_x0", {r, g, b}, 24'h5AC33C);
`endif
    for (int i = 0; i < 14; i++) cyc();
`ifdef VGA_TEST_PATTERN_EN
    chk("pattern_bar7", {r, g, b}, 24'hFFFFFF);
`else
    chk("passthru_x7", {r, g, b}, 24'h5AC33C);
`endif
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 299) != 0;
      en = $urandom_range(0, 7) != 0;
      pattern_sel = 1'($urandom);
      pix_r = 8'($urandom); pix_g = 8'($urandom); pix_b = 8'($urandom);
      cyc();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
